// File: rtl/fir_bram_pkg.sv
// ============================================================================
// Module : fir_bram_pkg
// Brief  : Shared encodings for the user-BRAM access arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_WB  = 1'b0,
    OWN_ENG = 1'b1
  } owner_e;

  localparam logic [15:0] DEC_HI_DEFAULT = 16'h3800;
  localparam int          CNT_W          = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way combinational round-robin arbiter; bit0 = WB, bit1 = engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import fir_bram_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == OWN_ENG) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bram_access_arbiter.sv
// ============================================================================
// Module : bram_access_arbiter
// Brief  : Shares the single-port user BRAM between Wishbone and the FIR engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_access_arbiter
  import fir_bram_pkg::*;
#(
  parameter int          BITS     = 32,
  parameter int          BRAM_LAT = 2,
  parameter int          ENG_AW   = 12,
  parameter logic [15:0] DEC_HI   = DEC_HI_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [BITS-1:0]   wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [BITS-1:0]   wbs_dat_o,
  input  logic              eng_req,
  input  logic [3:0]        eng_we,
  input  logic [ENG_AW-1:0] eng_adr,
  input  logic [BITS-1:0]   eng_wdat,
  output logic              eng_ack,
  output logic [BITS-1:0]   eng_rdat,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_a,
  output logic [BITS-1:0]   bram_di,
  input  logic [BITS-1:0]   bram_do
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BRAM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  logic [31:0]      adr_q, adr_d;
  logic [BITS-1:0]  wdat_q, wdat_d;
  logic [3:0]       we_q, we_d;
  logic             wb_ack_q, wb_ack_d;
  logic             eng_ack_q, eng_ack_d;
  logic [BITS-1:0]  wb_dat_q, wb_dat_d;
  logic [BITS-1:0]  eng_dat_q, eng_dat_d;

  logic             wb_req;
  logic [1:0]       gnt;

  assign wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == DEC_HI);

  rr_arb2 u_arb (
    .req_i  ({eng_req, wb_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    wb_ack_d  = 1'b0;
    eng_ack_d = 1'b0;
    wb_dat_d  = wb_dat_q;
    eng_dat_d = eng_dat_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt[1]) begin
          owner_d = OWN_ENG;
          adr_d   = {{(32-ENG_AW){1'b0}}, eng_adr};
          wdat_d  = eng_wdat;
          we_d    = eng_we;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else if (gnt[0]) begin
          owner_d = OWN_WB;
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          we_d    = wbs_we_i ? wbs_sel_i : 4'b0000;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          if (owner_q == OWN_ENG) begin
            eng_dat_d = bram_do;
            eng_ack_d = 1'b1;
          end else begin
            wb_dat_d  = bram_do;
            // A master that dropped cyc has abandoned the cycle: finish silently.
            wb_ack_d  = wbs_cyc_i;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_WB;
      last_q    <= OWN_ENG;
      adr_q     <= '0;
      wdat_q    <= '0;
      we_q      <= '0;
      wb_ack_q  <= 1'b0;
      eng_ack_q <= 1'b0;
      wb_dat_q  <= '0;
      eng_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      wb_ack_q  <= wb_ack_d;
      eng_ack_q <= eng_ack_d;
      wb_dat_q  <= wb_dat_d;
      eng_dat_q <= eng_dat_d;
    end
  end

  // Write strobes only on the first BUSY cycle so each write lands exactly once.
  assign bram_en   = (state_q == ST_BUSY);
  assign bram_we   = (state_q == ST_BUSY && cnt_q == '0) ? we_q : 4'b0000;
  assign bram_a    = adr_q;
  assign bram_di   = wdat_q;
  assign wbs_ack_o = wb_ack_q;
  assign wbs_dat_o = wb_dat_q;
  assign eng_ack   = eng_ack_q;
  assign eng_rdat  = eng_dat_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_access_arbiter.sv
// ============================================================================
// Module : tb_bram_access_arbiter
// Brief  : Scoreboard bench for bram_access_arbiter with a write-first BRAM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        eng_req;
  logic [3:0]  eng_we;
  logic [11:0] eng_adr;
  logic [31:0] eng_wdat;
  logic        eng_ack;
  logic [31:0] eng_rdat;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_a, bram_di;
  logic [31:0] bram_do = 32'h0;

  bram_access_arbiter dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .eng_req   (eng_req),
    .eng_we    (eng_we),
    .eng_adr   (eng_adr),
    .eng_wdat  (eng_wdat),
    .eng_ack   (eng_ack),
    .eng_rdat  (eng_rdat),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_a    (bram_a),
    .bram_di   (bram_di),
    .bram_do   (bram_do)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write-first BRAM, one registered read stage.
  logic [31:0] mem [0:255];
  logic [31:0] nxt;
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4]    = 32'h1111_0004;
      mem[8]    = 32'h2222_0008;
      mem_ready = 1'b1;
    end else if (bram_en) begin
      nxt = mem[bram_a[9:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) nxt[8*b +: 8] = bram_di[8*b +: 8];
      mem[bram_a[9:2]] = nxt;
      bram_do <= nxt;
    end
  end

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t wb_q[$];
  exp_t eng_q[$];
  exp_t e_wb, e_eng;
  int   checks = 0;
  int   errors = 0;
  int   wb_ack_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops an expectation for every ack the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (wbs_ack_o) begin
        wb_ack_cnt++;
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected_ack: got ack data %0h at cycle %0d, expected no ack", wbs_dat_o, cyc);
        end else begin
          e_wb = wb_q.pop_front();
          check("wb_data", wbs_dat_o, e_wb.dat);
          check("wb_ack_cycle", 64'(cyc), 64'(e_wb.cyc));
        end
      end
      if (eng_ack) begin
        if (eng_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL eng_unexpected_ack: got ack data %0h at cycle %0d, expected no ack", eng_rdat, cyc);
        end else begin
          e_eng = eng_q.pop_front();
          check("eng_data", eng_rdat, e_eng.dat);
          check("eng_ack_cycle", 64'(cyc), 64'(e_eng.cyc));
        end
      end
    end
  end

  task automatic wait_ack(input bit is_eng, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_eng ? eng_ack : wbs_ack_o) && n < 20);
    if (!(is_eng ? eng_ack : wbs_ack_o)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack within 20 cycles, expected ack", name);
    end
  endtask

  task automatic wb_txn(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] exp_dat, input int lat);
    exp_t x;
    x.dat = exp_dat;
    x.cyc = cyc + lat;
    wb_q.push_back(x);
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wait_ack(1'b0, "wb");
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic eng_txn(input logic [11:0] adr, input logic [3:0] we,
                         input logic [31:0] wdat, input logic [31:0] exp_dat, input int lat);
    exp_t x;
    x.dat = exp_dat;
    x.cyc = cyc + lat;
    eng_q.push_back(x);
    eng_adr = adr; eng_we = we; eng_wdat = wdat; eng_req = 1'b1;
    wait_ack(1'b1, "eng");
    @(posedge clk); #1;
    eng_req = 1'b0; eng_we = 4'b0000;
  endtask

  logic [7:0]  seq_v;
  logic [31:0] samp_a, samp_d;
  int          ack_base;

  initial begin
    rst = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    eng_req = 0; eng_we = 0; eng_adr = 0; eng_wdat = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_acks_en_we", {wbs_ack_o, eng_ack, bram_en, bram_we}, 7'b0);
    check("rst_dat_outs", {wbs_dat_o, eng_rdat}, 64'h0);
    check("rst_bram_a_di", {bram_a, bram_di}, 64'h0);
    @(posedge clk); #1;

    // WB read alone: enable for exactly two cycles, ack three cycles after request.
    fork
      wb_txn(32'h3800_0010, 1'b0, 4'hF, 32'h0, 32'h1111_0004, 3);
      begin
        seq_v = '0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          seq_v[3-i] = bram_en;
          if (i == 1) samp_a = bram_a;
        end
        check("wb_rd_en_pattern", {60'h0, seq_v[3:0]}, 64'b0110);
        check("wb_rd_bram_a", samp_a, 32'h3800_0010);
      end
    join

    // WB partial write: strobes only in the first BUSY cycle.
    fork
      wb_txn(32'h3800_0040, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0000_BEEF, 3);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (i == 1) begin seq_v[7:4] = bram_we; samp_d = bram_di; end
          if (i == 2) seq_v[3:0] = bram_we;
        end
        check("wb_wr_we_pattern", {56'h0, seq_v}, 64'h30);
        check("wb_wr_bram_di", samp_d, 32'hDEAD_BEEF);
      end
    join
    wb_txn(32'h3800_0040, 1'b0, 4'hF, 32'h0, 32'h0000_BEEF, 3);

    // Simultaneous pairs right after reset: WB first each time.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fork
      wb_txn(32'h3800_0010, 1'b0, 4'hF, 32'h0, 32'h1111_0004, 3);
      eng_txn(12'h020, 4'b0000, 32'h0, 32'h2222_0008, 7);
    join
    fork
      wb_txn(32'h3800_0020, 1'b0, 4'hF, 32'h0, 32'h2222_0008, 3);
      eng_txn(12'h010, 4'b0000, 32'h0, 32'h1111_0004, 7);
    join

    // Engine write: address zero-extended, byte lanes honoured, WB readback.
    fork
      eng_txn(12'h0C0, 4'b1100, 32'hCAFE_F00D, 32'hCAFE_0000, 3);
      begin
        @(negedge clk);
        @(negedge clk);
        samp_a = bram_a;
        check("eng_wr_bram_a", samp_a, 32'h0000_00C0);
      end
    join
    wb_txn(32'h3800_00C0, 1'b0, 4'hF, 32'h0, 32'hCAFE_0000, 3);

    // Undecoded WB address held while the engine reads.
    ack_base = wb_ack_cnt;
    wbs_adr_i = 32'h3000_0000; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    eng_txn(12'h020, 4'b0000, 32'h0, 32'h2222_0008, 3);
    repeat (6) @(posedge clk);
    #1 wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("undecoded_wb_acks", 64'(wb_ack_cnt - ack_base), 64'h0);

    // Reset pulsed during BUSY aborts the access.
    ack_base = wb_ack_cnt;
    wbs_adr_i = 32'h3800_0010; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy_en_low", {63'h0, bram_en}, 64'h0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_busy_no_ack", 64'(wb_ack_cnt - ack_base), 64'h0);
    wb_txn(32'h3800_0020, 1'b0, 4'hF, 32'h0, 32'h2222_0008, 3);

    // WB cycle abandoned mid-BUSY; queued engine request follows at the normal spacing.
    ack_base = wb_ack_cnt;
    wbs_adr_i = 32'h3800_0010; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0;
    fork
      eng_txn(12'h010, 4'b0000, 32'h0, 32'h1111_0004, 6);
      begin
        #2 wbs_stb_i = 1'b0;
      end
    join
    check("abort_no_wb_ack", 64'(wb_ack_cnt - ack_base), 64'h0);

    repeat (5) @(posedge clk);
    #1;
    check("wb_queue_empty", 64'(wb_q.size()), 64'h0);
    check("eng_queue_empty", 64'(eng_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
